// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready on both sides, four status flags and
// an internal accumulator.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand beat handshake (A, B, op_sel)
//   acc_clr             single-cycle accumulator clear, independent of handshake
//   out_valid/out_ready result handshake
//   result, carry, overflow, zero, negative   registered result and flags
//   acc                 current accumulator value
//
// Build option: define SEQ_ALU_SAT_EN to clamp add/acc to all-ones on carry-out
// and sub to zero on borrow. Without it all arithmetic wraps.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpShl = 3'b101,
    OpShr = 3'b110,
    OpAcc = 3'b111
  } op_e;

  localparam int unsigned Msb = WIDTH - 1;
  localparam logic [WIDTH:0] WidthVal = (WIDTH + 1)'(WIDTH);

  // State
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Datapath
  op_e              op;
  logic             accept;
  logic [WIDTH-1:0] acc_in;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] fin;
  logic             cy;
  logic             ov;
  logic             shift_oob;

  assign op       = op_e'(op_sel);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // A clear coinciding with an acc op makes that op start from zero.
  assign acc_in   = acc_clr ? '0 : acc_q;
  assign shift_oob = {1'b0, B} >= WidthVal;

  always_comb begin
    ext = '0;
    raw = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    case (op)
      OpAdd: begin
        ext = {1'b0, A} + {1'b0, B};
        raw = ext[WIDTH-1:0];
        cy  = ext[WIDTH];
        ov  = (A[Msb] == B[Msb]) && (raw[Msb] != A[Msb]);
      end
      OpSub: begin
        // Top bit of the extended difference is the borrow (A < B unsigned).
        ext = {1'b0, A} - {1'b0, B};
        raw = ext[WIDTH-1:0];
        cy  = ext[WIDTH];
        ov  = (A[Msb] != B[Msb]) && (raw[Msb] != A[Msb]);
      end
      OpAnd: raw = A & B;
      OpOr:  raw = A | B;
      OpXor: raw = A ^ B;
      OpShl: raw = shift_oob ? '0 : (A << B);
      OpShr: raw = shift_oob ? '0 : (A >> B);
      OpAcc: begin
        ext = {1'b0, acc_in} + {1'b0, A};
        raw = ext[WIDTH-1:0];
        cy  = ext[WIDTH];
        ov  = (acc_in[Msb] == A[Msb]) && (raw[Msb] != acc_in[Msb]);
      end
      default: raw = '0;
    endcase
  end

  // Clamp stage; carry and overflow keep reporting the unclamped value.
  always_comb begin
    fin = raw;
`ifdef SEQ_ALU_SAT_EN
    if ((op == OpAdd || op == OpAcc) && cy) begin
      fin = '1;
    end else if (op == OpSub && cy) begin
      fin = '0;
    end
`endif
  end

  // Next-state
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    acc_d       = acc_q;

    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = fin;
      carry_d     = cy;
      overflow_d  = ov;
      zero_d      = (fin == '0);
      negative_d  = fin[Msb];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept && op == OpAcc) begin
      acc_d = fin;
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8). The driver pushes the expected
// response of each accepted beat; a monitor pops and compares on every
// consumed result.
module tb_seq_alu;

  localparam int W    = 8;
  localparam int MODV = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [2:0]   op_sel;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic [W-1:0] acc;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a_in),
    .B        (b_in),
    .op_sel   (op_sel),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative),
    .acc      (acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int cy;
    int ov;
    int z;
    int n;
    int ac;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   pops    = 0;
  int   stalls  = 0;
  int   acc_m   = 0;
  bit   rnd_done;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= MODV / 2) ? v - MODV : v;
  endfunction

  // Reference: plain integer arithmetic on operand values.
  function automatic exp_t model(input int a, input int b, input int op, input int acc_v);
    exp_t e;
    int   s;
    int   sv;
    bit   sat_en;
`ifdef SEQ_ALU_SAT_EN
    sat_en = 1'b1;
`else
    sat_en = 1'b0;
`endif
    e.cy = 0;
    e.ov = 0;
    case (op)
      0, 7: begin
        int x;
        x = (op == 0) ? b : acc_v;
        s  = a + x;
        sv = sx(a) + sx(x);
        e.cy  = (s >= MODV) ? 1 : 0;
        e.ov  = (sv > 127 || sv < -128) ? 1 : 0;
        e.res = s % MODV;
        if (sat_en && e.cy == 1) e.res = MODV - 1;
      end
      1: begin
        s  = a - b;
        sv = sx(a) - sx(b);
        e.cy  = (a < b) ? 1 : 0;
        e.ov  = (sv > 127 || sv < -128) ? 1 : 0;
        e.res = (s + MODV) % MODV;
        if (sat_en && e.cy == 1) e.res = 0;
      end
      2: e.res = a & b;
      3: e.res = a | b;
      4: e.res = a ^ b;
      5: e.res = (b >= W) ? 0 : (a * (1 << b)) % MODV;
      6: e.res = (b >= W) ? 0 : a / (1 << b);
      default: e.res = 0;
    endcase
    e.z = (e.res == 0) ? 1 : 0;
    e.n = (e.res >= MODV / 2) ? 1 : 0;
    return e;
  endfunction

  task automatic send(input int a, input int b, input int op, input bit clr);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = W'(a);
    b_in     = W'(b);
    op_sel   = 3'(op);
    acc_clr  = clr;
    for (int t = 0; ; t++) begin
      #1;
      if (in_ready) break;
      if (t >= 100) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        return;
      end
      stalls++;
      @(negedge clk);
    end
    if (clr) acc_m = 0;
    e = model(a, b, op, acc_m);
    if (op == 7) acc_m = e.res;
    e.ac = acc_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  // Monitor: a result presented with out_ready high is consumed at the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result",   int'(result),   e.res);
          check("carry",    int'(carry),    e.cy);
          check("overflow", int'(overflow), e.ov);
          check("zero",     int'(zero),     e.z);
          check("negative", int'(negative), e.n);
          check("acc",      int'(acc),      e.ac);
        end
        pops++;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_result"},    int'(result),    0);
    check({tag, "_carry"},     int'(carry),     0);
    check({tag, "_overflow"},  int'(overflow),  0);
    check({tag, "_zero"},      int'(zero),      0);
    check({tag, "_negative"},  int'(negative),  0);
    check({tag, "_acc"},       int'(acc),       0);
  endtask

  int p0;
  int s0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; op_sel = '0;
    acc_clr = 1'b0; out_ready = 1'b1;
    #1;
    check_all_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_release", int'(in_ready), 1);

    // Directed add/sub/logic/shift
    send(8'hF0, 8'h20, 0, 1'b0);
    send(8'h10, 8'h20, 1, 1'b0);
    send(8'h7F, 8'h01, 0, 1'b0);
    send(8'hCC, 8'hAA, 2, 1'b0);
    send(8'h81, 1, 5, 1'b0);
    send(8'h81, 7, 6, 1'b0);
    send(8'h81, 8, 5, 1'b0);
    send(8'h5A, 8'h0F, 3, 1'b0);
    send(8'h5A, 8'hFF, 4, 1'b0);
    send(8'h80, 8'h01, 1, 1'b0);

    // Accumulator: 5, 12, 6 (carry) then clear coinciding with A=3
    send(5, 0, 7, 1'b1);
    send(7, 0, 7, 1'b0);
    send(250, 0, 7, 1'b0);
    send(3, 0, 7, 1'b1);
    @(negedge clk); #1;
    check("acc_after_clr_op", int'(acc), 3);
    // Standalone clear
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    acc_m   = 0;
    check("acc_after_clr", int'(acc), 0);

    // Backpressure: 4 adds, out_ready low for 3 cycles
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send($urandom_range(0, 255), $urandom_range(0, 255), 0, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        #1;
        check("bp_in_ready_low", int'(in_ready), 0);
        if (sb.size() > 0) check("bp_hold0", int'(result), sb[0].res);
        @(negedge clk); #1;
        if (sb.size() > 0) check("bp_hold1", int'(result), sb[0].res);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    check("bp_drained", sb.size(), 0);

    // Throughput: 16 back-to-back beats with out_ready=1
    p0 = pops;
    s0 = stalls;
    for (int i = 0; i < 16; i++) begin
      int op;
      op = $urandom_range(0, 7);
      send($urandom_range(0, 255),
           (op >= 5 && op <= 6) ? $urandom_range(0, 9) : $urandom_range(0, 255), op, 1'b0);
    end
    repeat (2) @(negedge clk);
    #3;
    check("tput_stalls", stalls - s0, 0);
    check("tput_results", pops - p0, 16);

    // Random traffic with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          int op;
          op = $urandom_range(0, 7);
          send($urandom_range(0, 255),
               (op >= 5 && op <= 6) ? $urandom_range(0, 10) : $urandom_range(0, 255),
               op, ($urandom_range(0, 15) == 0));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    check("random_drained", sb.size(), 0);

    // Reset mid-stream with a pending result
    out_ready = 1'b0;
    send(8'h33, 8'h44, 0, 1'b0);
    @(negedge clk); #1;
    check("pre_reset_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    sb.delete();
    acc_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("in_ready_after_reset", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    #1;
    check("no_stale_valid", int'(out_valid), 0);

    send(8'h01, 8'h01, 0, 1'b0);
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
    #3;
    check("final_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with a valid/ready handshake on both sides, a four-bit status flag set, and an internal accumulator. It generalises the team's 4-bit combinational ALU to any width and eight operations, and adds registered results, backpressure and accumulate mode. It sits between an operand-issuing controller and a result consumer inside datapath blocks.

## Interface
- WIDTH, 8, operand, result and accumulator width (≥ 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand/op beat valid
- in_ready  out  1  block can accept a beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B (shift amount for shifts)
- op_sel  in  3  operation select
- acc_clr  in  1  clear accumulator (single-cycle pulse, independent of handshake)
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer accepts result this cycle
- result  out  WIDTH  registered result
- carry  out  1  carry-out / borrow
- overflow  out  1  signed overflow
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- acc  out  WIDTH  current accumulator value

## Operation
- A beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This gives a one-deep output register with full throughput under continuous out_ready.
- op_sel encoding:
  - 000 add: {carry,result} = A+B
  - 001 sub: result = A−B, carry = borrow (A<B unsigned)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 shl: A << B
  - 110 shr: A >> B (logical)
  - 111 acc: {carry,result} = acc+A, and acc ← result
- Shift: if B ≥ WIDTH then result = 0. carry = 0 for shifts and logic ops.
- overflow: signed two's-complement overflow for add/sub/acc; 0 otherwise.
- zero and negative are computed on the final registered result, after saturation when saturation is compiled in.
- acc_clr sets acc to 0 on the next edge. If acc_clr coincides with an accepted acc op, the op uses 0 as the accumulator input, so result = A and acc ← A.
- acc changes only on an accepted acc op or on acc_clr. Stalled beats never update it.
- While out_valid && !out_ready, result and all flags hold stable.

## Timing
- Latency 1 cycle: a beat accepted at edge N gives out_valid=1 with its result after edge N.
- Throughput is one beat per cycle while out_ready=1.
- out_valid falls after the consuming edge unless a new beat is accepted on that same edge.
- Reset (async assert, sync release) sets out_valid, result, carry, overflow, zero, negative and acc to 0.
- Reset mid-transaction discards any pending result. in_ready is 1 on the first cycle after release.

## Configuration
- SEQ_ALU_SAT_EN defined:
  - add/acc clamp to all-ones on unsigned carry-out; sub clamps to 0 on borrow.
  - carry still reports the unclamped carry/borrow; overflow is computed on the unclamped value.
  - For acc ops, acc stores the clamped value.
- Undefined: all arithmetic wraps modulo 2^WIDTH.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → all outputs 0 immediately; in_ready=1 after release; no stale result appears.
- Add/sub, WIDTH=8:
  - 0xF0+0x20 → result 0x10, carry=1, overflow=0 (saturated build: 0xFF, carry=1).
  - 0x10−0x20 → result 0xF0, carry=1, negative=1 (saturated build: 0x00, zero=1).
  - 0x7F+0x01 → result 0x80, overflow=1, negative=1.
- Logic/shift:
  - 0xCC AND 0xAA → 0x88.
  - 0x81 shl 1 → 0x02.
  - 0x81 shr 7 → 0x01.
  - shl by 8 → 0x00, zero=1.
- Backpressure: stream 4 adds with out_ready=0 for 3 cycles → in_ready=0 after the first accept; result holds; all 4 results delivered in order with none lost or duplicated.
- Accumulator:
  - acc ops with A=5, 7, 250 → results 5, 12, 6 with carry=1 on the third (saturated build: 0xFF).
  - acc_clr asserted on the same cycle as an acc op with A=3 → result 3, acc=3.
- Throughput: 16 back-to-back random beats with out_ready=1 → 16 results on 16 consecutive cycles, each matching the reference model.
